time_snapshot_tx: RTL

//   Consumer end of the calendar/clock counter bus (year/month/day/hour/minute/second).
//   On a capture request, freezes one coherent 32-bit time snapshot.

---
 rtl/time_snapshot_tx_if.sv | 10 +
 rtl/time_snapshot_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/time_snapshot_tx_if.sv
// Byte stream from the snapshot transmitter to a UART/log sink.
// A byte moves on a rising edge where tx_valid and tx_ready are both high.
interface time_snapshot_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/time_snapshot_tx.sv
// time_snapshot_tx: freezes a coherent calendar snapshot on capture and streams it as a
// SYNC + 4 data byte frame; `define TX_CHECKSUM_EN appends an XOR checksum byte.
module time_snapshot_tx #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         year,
    input  logic [3:0]         month,
    input  logic [4:0]         day,
    input  logic [4:0]         hour,
    input  logic [5:0]         minute,
    input  logic [5:0]         second,
    input  logic               capture,
    input  logic               clr_overrun,
    time_snapshot_tx_if.master tx,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_CSUM,
        S_GAP
    } state_t;

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam state_t LAST_NXT = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
`ifdef TX_CHECKSUM_EN
    localparam state_t DATA_NXT = S_CSUM;
`else
    localparam state_t DATA_NXT = LAST_NXT;
`endif

    state_t        state, state_nxt;
    logic [1:0]    idx, idx_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [31:0]   snap;
    logic          snap_ld;
    logic          valid_c;
    logic [7:0]    data_c;

    function automatic logic [7:0] snap_byte(input logic [31:0] s, input logic [1:0] i);
        case (i)
            2'd0:    return s[31:24];
            2'd1:    return s[23:16];
            2'd2:    return s[15:8];
            default: return s[7:0];
        endcase
    endfunction

`ifdef TX_CHECKSUM_EN
    function automatic logic [7:0] snap_csum(input logic [31:0] s);
        return s[31:24] ^ s[23:16] ^ s[15:8] ^ s[7:0];
    endfunction
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            idx     <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            gap_cnt <= gap_nxt;
        end
    end

    // Bytes are driven straight from the frozen snapshot, so tx_data is stable while stalled.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        gap_nxt   = gap_cnt;
        snap_ld   = 1'b0;
        valid_c   = 1'b0;
        data_c    = '0;
        case (state)
            S_IDLE: begin
                if (capture) begin
                    snap_ld   = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                valid_c = 1'b1;
                data_c  = SYNC_BYTE;
                if (tx.tx_ready) begin
                    state_nxt = S_DATA;
                    idx_nxt   = '0;
                end
            end
            S_DATA: begin
                valid_c = 1'b1;
                data_c  = snap_byte(snap, idx);
                if (tx.tx_ready) begin
                    if (idx == 2'd3) state_nxt = DATA_NXT;
                    else             idx_nxt   = idx + 2'd1;
                end
            end
`ifdef TX_CHECKSUM_EN
            S_CSUM: begin
                valid_c = 1'b1;
                data_c  = snap_csum(snap);
                if (tx.tx_ready) state_nxt = LAST_NXT;
            end
`endif
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_nxt = S_IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       snap <= '0;
        else if (snap_ld) snap <= {year, month, day, hour, minute, second};
    end

    // A capture seen while busy is dropped; flagging it takes priority over a clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                overrun <= 1'b0;
        else if (capture && busy)  overrun <= 1'b1;
        else if (clr_overrun)      overrun <= 1'b0;
    end

    assign busy        = (state != S_IDLE);
    assign tx.tx_valid = valid_c;
    assign tx.tx_data  = data_c;

endmodule
